load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 21 ++
 rtl/load_store_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit and memory.
// master = LSU side, slave = memory side.
interface load_store_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ack;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, ack
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: IDLE/WAIT/DONE bus FSM with timeout.
// Optional macro LSU_MISALIGN_TRAP_EN traps misaligned accesses.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] alu_out,
  input  logic [31:0] store_data,
  input  logic [2:0]  funct3,
  load_store_unit_if.master dmem,
  output logic [31:0] load_data,
  output logic        done,
  output logic        stall,
  output logic        misalign,
  output logic        bus_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t state;
  state_t nextState;

  logic          accept;
  logic          trap;
  logic          isHalf;
  logic          isWord;
  logic          timeout;
  logic [CW-1:0] waitCnt;
  logic [31:0]   alignedAddr;
  logic [3:0]    beNext;
  logic [31:0]   wdataNext;

  logic [31:0]   addrReg;
  logic [31:0]   wdataReg;
  logic [3:0]    beReg;
  logic          weReg;
  logic [2:0]    f3Reg;
  logic          errReg;

  logic [31:0]   laneData;
  logic [31:0]   fmtData;

  assign accept = (state == IDLE) && ex_valid
                && (mem_read || mem_write);
  assign isHalf = (funct3[1:0] == 2'b01);
  assign isWord = funct3[1];
  assign timeout = (waitCnt == CW'(TIMEOUT_CYCLES - 1));

`ifdef LSU_MISALIGN_TRAP_EN
  logic misAddr;
  logic misReg;

  assign misAddr = (isHalf && alu_out[0])
                 || (isWord && (alu_out[1:0] != 2'b00));
  assign trap = misAddr;
  assign alignedAddr = alu_out;

  // Remember whether this access was trapped.
  always_ff @(posedge clk) begin
    if (rst)
      misReg <= 1'b0;
    else if (accept)
      misReg <= misAddr;
  end
`else
  assign trap = 1'b0;

  // Misaligned addresses round down to the access size.
  always_comb begin
    alignedAddr = alu_out;
    unique case (1'b1)
      isWord:  alignedAddr = {alu_out[31:2], 2'b00};
      isHalf:  alignedAddr = {alu_out[31:1], 1'b0};
      default: alignedAddr = alu_out;
    endcase
  end
`endif

  // Byte enables and lane-replicated store data.
  always_comb begin
    beNext = 4'b0000;
    wdataNext = store_data;
    unique case (1'b1)
      isWord: begin
        if (mem_write)
          beNext = 4'b1111;
        wdataNext = store_data;
      end
      isHalf: begin
        if (mem_write)
          beNext = 4'b0011 << {alignedAddr[1], 1'b0};
        wdataNext = {2{store_data[15:0]}};
      end
      default: begin
        if (mem_write)
          beNext = 4'b0001 << alignedAddr[1:0];
        wdataNext = {4{store_data[7:0]}};
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= nextState;
  end

  // Next-state logic; ack has priority over timeout.
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (accept)
          nextState = trap ? DONE : WAIT;
      end
      WAIT: begin
        if (dmem.ack || timeout)
          nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs decoded from state and registered request.
  always_comb begin
    dmem.req   = (state == WAIT);
    dmem.we    = weReg;
    dmem.be    = beReg;
    dmem.addr  = {addrReg[31:2], 2'b00};
    dmem.wdata = wdataReg;
    stall      = accept || (state == WAIT);
    done       = (state == DONE);
    bus_err    = (state == DONE) && errReg;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign   = (state == DONE) && misReg;
`else
    misalign   = 1'b0;
`endif
  end

  // Capture the request on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      addrReg  <= '0;
      wdataReg <= '0;
      beReg    <= '0;
      weReg    <= 1'b0;
      f3Reg    <= '0;
    end else if (accept) begin
      addrReg  <= alignedAddr;
      wdataReg <= wdataNext;
      beReg    <= beNext;
      weReg    <= mem_write;
      f3Reg    <= funct3;
    end
  end

  // Wait-cycle counter, zero outside WAIT.
  always_ff @(posedge clk) begin
    if (rst)
      waitCnt <= '0;
    else if (state != WAIT)
      waitCnt <= '0;
    else if (!dmem.ack)
      waitCnt <= waitCnt + 1'b1;
  end

  // Select and extend the addressed lane.
  always_comb begin
    laneData = dmem.rdata >> {addrReg[1:0], 3'b000};
    fmtData = dmem.rdata;
    unique case (f3Reg)
      3'b000:  fmtData = {{24{laneData[7]}}, laneData[7:0]};
      3'b001:  fmtData = {{16{laneData[15]}}, laneData[15:0]};
      3'b100:  fmtData = {24'h0, laneData[7:0]};
      3'b101:  fmtData = {16'h0, laneData[15:0]};
      default: fmtData = dmem.rdata;
    endcase
  end

  // Load result and bus-error flag, settled on WAIT exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_data <= '0;
      errReg    <= 1'b0;
    end else begin
      if (accept)
        errReg <= 1'b0;
      if (state == WAIT) begin
        if (dmem.ack) begin
          errReg <= 1'b0;
          if (!weReg)
            load_data <= fmtData;
        end else if (timeout) begin
          errReg    <= 1'b1;
          load_data <= '0;
        end
      end
    end
  end

endmodule
